// File: rtl/ysyx_23060061_pkg.sv
// Shared definitions for the ysyx_23060061 core: the IFU state encoding, the
// default boot address and the AXI response code used to detect fetch errors.
package ysyx_23060061_pkg;

    // IFU fetch states; at most one read is outstanding at any time
    typedef enum logic [1:0] {
        ST_REQ       = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_OUT       = 2'd2,
        ST_WAIT_PC   = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

    // A fetch address that is not word aligned cannot be issued on the bus
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: issues one AXI-Lite read per instruction, hands the
// result to decode, then waits for writeback to supply the next PC.
// Every handshake output comes straight from a flop so no input reaches an
// output combinationally.
module ysyx_23060061_ifu
    import ysyx_23060061_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        npc_ready
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        inst_valid_q, inst_valid_d;
    logic        npc_ready_q, npc_ready_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_err_q, inst_err_d;

    logic        ar_hs_s;
    logic        r_hs_s;
    logic        out_hs_s;
    logic        npc_hs_s;
    logic        npc_bad_s;

    // Handshakes are qualified by the registered valid/ready so inputs seen
    // outside their owning state have no effect.
    assign ar_hs_s   = arvalid_q && arready;
    assign r_hs_s    = rready_q && rvalid;
    assign out_hs_s  = inst_valid_q && inst_ready;
    assign npc_hs_s  = npc_ready_q && npc_valid;
    assign npc_bad_s = pc_misaligned(npc);

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            npc_ready_q  <= 1'b0;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
            inst_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
            npc_ready_q  <= npc_ready_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
        end
    end

    // Next-state selection driven by the four handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (ar_hs_s) begin
                    state_d = ST_WAIT_DATA;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT_DATA: begin
                if (r_hs_s) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_OUT: begin
                if (out_hs_s) begin
                    state_d = ST_WAIT_PC;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_WAIT_PC: begin
                if (npc_hs_s) begin
                    // A misaligned target never reaches the bus; it is
                    // reported to decode as a faulting fetch instead.
                    if (npc_bad_s) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_WAIT_PC;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Datapath updates and flop-based handshake outputs derived from next state
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;

        case (state_q)
            ST_WAIT_DATA: begin
                if (r_hs_s) begin
                    inst_d     = rdata;
                    inst_pc_d  = pc_q;
                    inst_err_d = (rresp != RESP_OKAY);
                end else begin
                    inst_d     = inst_q;
                end
            end
            ST_WAIT_PC: begin
                if (npc_hs_s) begin
                    pc_d = npc;
                    if (npc_bad_s) begin
                        inst_d     = 32'h0000_0000;
                        inst_pc_d  = npc;
                        inst_err_d = 1'b1;
                    end else begin
                        inst_d     = inst_q;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase

        // Registering these from the next state gives arvalid in the first
        // REQ cycle and inst_valid the cycle after the read-data handshake.
        arvalid_d    = (state_d == ST_REQ);
        rready_d     = (state_d == ST_WAIT_DATA);
        inst_valid_d = (state_d == ST_OUT);
        npc_ready_d  = (state_d == ST_WAIT_PC);
    end

    assign araddr     = pc_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_err   = inst_err_q;
    assign inst_valid = inst_valid_q;
    assign npc_ready  = npc_ready_q;

endmodule
